display_scheduler: RTL and testbench

- Sequences the LED-array pixel writer: owns a 16-byte frame buffer and periodically replays "display control" then 16 "address+data" transfers.
- Sits between the UART command parser (buffer write port and refresh requests) and the writepixels serializer (valid/pos/value/busy).
- Replaces the inline refresh state machine in the top level and makes the writer handshake robust.

---
 rtl/display_scheduler_if.sv | 25 ++
 rtl/display_scheduler.sv | 177 +++++++++++++++++
 tb/tb_display_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scheduler_if.sv
// Writer-side handshake bundle between the display scheduler and the
// writepixels serializer: a one-cycle valid strobe carrying a command/address
// byte and a data byte, answered by the writer's busy flag.
interface display_scheduler_if;
    logic       valid;
    logic [7:0] pos;
    logic [7:0] value;
    logic       busy;

    // The scheduler drives transfers and watches busy.
    modport master (
        output valid,
        output pos,
        output value,
        input  busy
    );

    // The writer consumes transfers and reports busy.
    modport slave (
        input  valid,
        input  pos,
        input  value,
        output busy
    );
endinterface

// File: rtl/display_scheduler.sv
// Display scheduler for the LED-array pixel writer.
// Owns a 16-byte frame buffer filled by the UART command parser. Whenever a
// frame is pending (periodic tick or explicit request), it sends one display
// control byte, waits a fixed pause, then sends the 16 address+data transfers.
// Every transfer is a strict issue / wait-busy-high / wait-busy-low handshake,
// so the writer can never be handed a second strobe while it is still working.
module display_scheduler #(
    parameter int CLK_HZ       = 12_000_000,
    parameter int REFRESH_HZ   = 10,
    parameter int PAUSE_CYCLES = 12_000,
    parameter int NUM_COLS     = 16
) (
    input  logic                       CLK,
    input  logic                       i_RST_N,
    input  logic                       i_wr_en,
    input  logic [3:0]                 i_wr_addr,
    input  logic [7:0]                 i_wr_data,
    input  logic                       i_refresh_req,
    input  logic                       i_display_on,
    input  logic [2:0]                 i_brightness,
    display_scheduler_if.master        wr,
    output logic                       o_frame_active,
    output logic                       o_frame_done
);

    localparam int TICK_PERIOD = CLK_HZ / REFRESH_HZ;
    localparam int TICK_W      = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int PAUSE_W     = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_PERIOD - 1);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_CYCLES - 1);
    localparam logic [3:0]         LAST_COL   = 4'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CTRL,
        ST_PAUSE,
        ST_DATA
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_ACK,
        PH_DRAIN
    } phase_t;

    state_t              state;
    phase_t              phase;
    logic [3:0]          column;
    logic                pending;
    logic [PAUSE_W-1:0]  pause_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick_wrap;
    logic [7:0]          ctrl_byte;
    logic [7:0]          frame_buf [16];

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign ctrl_byte = {4'b1000, i_display_on, i_brightness};

    // Free-running refresh tick: wraps once per frame period.
    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            tick_cnt <= '0;
        end else if (tick_wrap) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Frame buffer write port, open in every state; columns are read only
    // when their transfer issues, so late writes land in the current frame
    // if that column has not gone out yet.
    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int i = 0; i < 16; i++) begin
                frame_buf[i] <= 8'h00;
            end
        end else if (i_wr_en) begin
            frame_buf[i_wr_addr] <= i_wr_data;
        end
    end

    // Frame sequencer: pending-trigger capture, control/pause/data ordering,
    // and the per-transfer issue/ack/drain handshake with registered outputs.
    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state          <= ST_IDLE;
            phase          <= PH_ISSUE;
            column         <= 4'd0;
            pending        <= 1'b0;
            pause_cnt      <= '0;
            wr.valid       <= 1'b0;
            wr.pos         <= 8'h00;
            wr.value       <= 8'h00;
            o_frame_active <= 1'b0;
            o_frame_done   <= 1'b0;
        end else begin
            wr.valid     <= 1'b0;
            o_frame_done <= 1'b0;

            if (tick_wrap || i_refresh_req) begin
                pending <= 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (pending) begin
                        pending        <= 1'b0;
                        column         <= 4'd0;
                        phase          <= PH_ISSUE;
                        state          <= ST_CTRL;
                        o_frame_active <= 1'b1;
                    end
                end

                ST_PAUSE: begin
                    if (pause_cnt == PAUSE_LAST) begin
                        phase <= PH_ISSUE;
                        state <= ST_DATA;
                    end else begin
                        pause_cnt <= pause_cnt + 1'b1;
                    end
                end

                ST_CTRL, ST_DATA: begin
                    unique case (phase)
                        PH_ISSUE: begin
                            if (!wr.busy) begin
                                wr.valid <= 1'b1;
                                phase    <= PH_ACK;
                                if (state == ST_CTRL) begin
                                    wr.pos   <= ctrl_byte;
                                    wr.value <= 8'h00;
                                end else begin
                                    wr.pos   <= {4'hC, column};
                                    wr.value <= frame_buf[column];
                                end
                            end
                        end

                        PH_ACK: begin
                            if (wr.busy) begin
                                phase <= PH_DRAIN;
                            end
                        end

                        PH_DRAIN: begin
                            if (!wr.busy) begin
                                phase <= PH_ISSUE;
                                if (state == ST_CTRL) begin
                                    pause_cnt <= '0;
                                    state     <= ST_PAUSE;
                                end else if (column == LAST_COL) begin
                                    o_frame_done   <= 1'b1;
                                    o_frame_active <= 1'b0;
                                    state          <= ST_IDLE;
                                end else begin
                                    column <= column + 1'b1;
                                end
                            end
                        end

                        default: begin
                            phase <= PH_ISSUE;
                        end
                    endcase
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: a busy-for-3-cycles writer model,
// a negedge monitor that logs every transfer, and hand-computed frames.
module tb_display_scheduler;

    localparam int CLK_HZ       = 50_000;
    localparam int REFRESH_HZ   = 10;
    localparam int PAUSE_CYCLES = 10;

    logic       CLK = 1'b0;
    logic       i_RST_N = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [3:0] i_wr_addr = 4'd0;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_refresh_req = 1'b0;
    logic       i_display_on = 1'b0;
    logic [2:0] i_brightness = 3'd0;
    logic       o_frame_active;
    logic       o_frame_done;

    display_scheduler_if wr_bus();

    display_scheduler #(
        .CLK_HZ       (CLK_HZ),
        .REFRESH_HZ   (REFRESH_HZ),
        .PAUSE_CYCLES (PAUSE_CYCLES),
        .NUM_COLS     (16)
    ) dut (
        .CLK            (CLK),
        .i_RST_N        (i_RST_N),
        .i_wr_en        (i_wr_en),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_refresh_req  (i_refresh_req),
        .i_display_on   (i_display_on),
        .i_brightness   (i_brightness),
        .wr             (wr_bus),
        .o_frame_active (o_frame_active),
        .o_frame_done   (o_frame_done)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_state = 0;
    int hs_viol = 0;
    int busy_cnt = 0;
    bit writer_auto = 1'b1;
    int req_edge = 0;
    int drop_edge = 0;

    logic [15:0] xfers [$];
    int          valid_cyc [$];
    int          drain_edge [$];
    int          done_cyc [$];
    logic [7:0]  exp_vals [16];

    // 100 MHz-style free clock.
    always #5 CLK = ~CLK;

    // Edge counter used to timestamp events.
    always @(posedge CLK) cyc++;

    // Monitor and writer model, sampled away from the active edge.
    always @(negedge CLK) begin
        if (wr_bus.valid === 1'b1) begin
            xfers.push_back({wr_bus.pos, wr_bus.value});
            valid_cyc.push_back(cyc);
            if (hs_state != 0) hs_viol++;
            hs_state = 1;
        end else if (hs_state == 1 && wr_bus.busy) begin
            hs_state = 2;
        end else if (hs_state == 2 && !wr_bus.busy) begin
            hs_state = 0;
        end
        if (o_frame_done === 1'b1) done_cyc.push_back(cyc);
        if (writer_auto) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    wr_bus.busy = 1'b0;
                    drain_edge.push_back(cyc + 1);
                end
            end else if (wr_bus.valid === 1'b1) begin
                wr_bus.busy = 1'b1;
                busy_cnt = 3;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        xfers.delete();
        valid_cyc.delete();
        drain_edge.delete();
        done_cyc.delete();
    endtask

    task automatic apply_reset();
        i_RST_N = 1'b0;
        i_wr_en = 1'b0;
        i_refresh_req = 1'b0;
        writer_auto = 1'b1;
        wr_bus.busy = 1'b0;
        busy_cnt = 0;
        hs_state = 0;
        wait_edges(3);
        check_output("rst_valid", 32'(wr_bus.valid), 0);
        check_output("rst_pos", 32'(wr_bus.pos), 0);
        check_output("rst_value", 32'(wr_bus.value), 0);
        check_output("rst_active", 32'(o_frame_active), 0);
        check_output("rst_done", 32'(o_frame_done), 0);
        i_RST_N = 1'b1;
        clear_log();
    endtask

    task automatic apply_stimulus(input logic [3:0] addr, input logic [7:0] data);
        i_wr_en = 1'b1;
        i_wr_addr = addr;
        i_wr_data = data;
        wait_edges(1);
        i_wr_en = 1'b0;
    endtask

    task automatic pulse_refresh();
        req_edge = cyc + 1;
        i_refresh_req = 1'b1;
        wait_edges(1);
        i_refresh_req = 1'b0;
    endtask

    task automatic wait_xfers(input int n, input int budget, input string tag);
        int b = budget;
        while (xfers.size() < n && b > 0) begin
            wait_edges(1);
            b--;
        end
        if (xfers.size() < n) check_output({tag, "_timeout"}, 32'(xfers.size()), 32'(n));
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int b = budget;
        while (done_cyc.size() < n && b > 0) begin
            wait_edges(1);
            b--;
        end
        if (done_cyc.size() < n) check_output({tag, "_done_timeout"}, 32'(done_cyc.size()), 32'(n));
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] ctrl);
        logic [15:0] got;
        logic [15:0] exp;
        for (int i = 0; i < 17; i++) begin
            got = (base + i < xfers.size()) ? xfers[base + i] : 16'hxxxx;
            exp = (i == 0) ? {ctrl, 8'h00} : {8'hC0 | 8'(i - 1), exp_vals[i - 1]};
            check_output($sformatf("%s_x%0d", tag, i), 32'(got), 32'(exp));
        end
    endtask

    initial begin
        int b;

        // Basic frame with incrementing data.
        $display("[TB] frame order and timing");
        apply_reset();
        i_display_on = 1'b1;
        i_brightness = 3'd1;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(4'(i), 8'(i));
            exp_vals[i] = 8'(i);
        end
        pulse_refresh();
        wait_xfers(1, 10, "t1_first");
        check_output("t1_active", 32'(o_frame_active), 1);
        wait_done(1, 200, "t1");
        check_frame("t1", 0, 8'h89);
        check_output("t1_done_count", 32'(done_cyc.size()), 1);
        check_output("t1_latency", 32'(valid_cyc[0] - req_edge), 2);
        check_output("t1_pause_gap", 32'(valid_cyc[1] - drain_edge[0]), 32'(PAUSE_CYCLES + 1));
        check_output("t1_done_edge", 32'(done_cyc[0]), 32'(drain_edge[16]));
        wait_edges(2);
        check_output("t1_idle_active", 32'(o_frame_active), 0);
        check_output("t1_xfer_count", 32'(xfers.size()), 17);

        // Writer busy before the request: nothing may issue until it drops.
        $display("[TB] busy held before request");
        clear_log();
        writer_auto = 1'b0;
        wr_bus.busy = 1'b1;
        pulse_refresh();
        wait_edges(40);
        check_output("t2_no_valid", 32'(xfers.size()), 0);
        check_output("t2_active", 32'(o_frame_active), 1);
        writer_auto = 1'b1;
        wr_bus.busy = 1'b0;
        drop_edge = cyc + 1;
        wait_xfers(1, 5, "t2_first");
        check_output("t2_drop_latency", 32'((valid_cyc[0] - drop_edge) <= 1), 1);
        wait_done(1, 200, "t2");
        check_frame("t2", 0, 8'h89);
        check_output("t2_handshake", 32'(hs_viol), 0);

        // Writes during a frame plus a mid-frame request.
        $display("[TB] writes while column 3 in flight");
        i_display_on = 1'b0;
        i_brightness = 3'd5;
        clear_log();
        pulse_refresh();
        wait_xfers(5, 60, "t3_col3");
        check_output("t3_col3_pos", 32'(xfers[4][15:8]), 32'h0C3);
        apply_stimulus(4'd15, 8'hAA);
        apply_stimulus(4'd0, 8'h55);
        pulse_refresh();
        wait_done(2, 400, "t3");
        exp_vals[15] = 8'hAA;
        check_frame("t3_a", 0, 8'h85);
        exp_vals[0] = 8'h55;
        check_frame("t3_b", 17, 8'h85);
        check_output("t3_back_to_back", 32'(valid_cyc[17] - done_cyc[0]), 2);
        wait_edges(150);
        check_output("t3_done_count", 32'(done_cyc.size()), 2);

        // Reset in the middle of column 7.
        $display("[TB] reset during data column 7");
        i_display_on = 1'b1;
        i_brightness = 3'd7;
        clear_log();
        pulse_refresh();
        b = 200;
        while (!(wr_bus.valid === 1'b1 && wr_bus.pos === 8'hC7) && b > 0) begin
            @(negedge CLK);
            #1;
            b--;
        end
        check_output("t4_reach_col7", 32'(wr_bus.pos), 32'h0C7);
        i_RST_N = 1'b0;
        #1;
        check_output("t4_valid", 32'(wr_bus.valid), 0);
        check_output("t4_pos", 32'(wr_bus.pos), 0);
        check_output("t4_active", 32'(o_frame_active), 0);
        check_output("t4_done", 32'(o_frame_done), 0);
        wait_edges(4);
        i_RST_N = 1'b1;
        clear_log();
        wait_edges(200);
        check_output("t4_quiet", 32'(xfers.size()), 0);
        check_output("t4_quiet_done", 32'(done_cyc.size()), 0);
        for (int i = 0; i < 16; i++) exp_vals[i] = 8'h00;
        pulse_refresh();
        wait_done(1, 200, "t4");
        check_frame("t4", 0, 8'h8F);

        // Request shortly before the periodic tick: tick lands mid-frame.
        $display("[TB] request and tick coalescing");
        apply_reset();
        wait_edges(4950);
        clear_log();
        pulse_refresh();
        wait_edges(350);
        check_output("t5_done_count", 32'(done_cyc.size()), 2);
        check_output("t5_xfer_count", 32'(xfers.size()), 34);
        check_output("t5_back_to_back", 32'(valid_cyc[17] - done_cyc[0]), 2);
        check_output("t5_second_ctrl", 32'(xfers[17]), 32'h8F00);
        check_output("final_handshake", 32'(hs_viol), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
